imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 40 ++++
 rtl/imm_decode.sv | 35 +++
 rtl/imm_gen_pipe.sv | 80 ++++++++
 tb/tb_imm_gen_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared format codes, RV opcode constants and opcode-to-format lookup
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OP_32   = 7'b0111011;

  // Full 7-bit match, so any word with inst[1:0] != 2'b11 lands in FMT_NONE.
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM: opcode_fmt = FMT_I;
      OP_STORE:                                       opcode_fmt = FMT_S;
      OP_BRANCH:                                      opcode_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                               opcode_fmt = FMT_U;
      OP_JAL:                                         opcode_fmt = FMT_J;
      OP_OP, OP_OP_32:                                opcode_fmt = FMT_R;
      default:                                        opcode_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode decode and sign-extended immediate assembly
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [XLEN-1:0] imm
);

  imm_fmt_e    f;
  logic [31:0] imm32;

  assign f       = opcode_fmt(inst[6:0]);
  assign fmt     = f;
  assign illegal = (f == FMT_NONE);

  // Every format keeps its sign in inst[31], so a 32-bit sign-extended value is built first.
  always_comb begin
    imm32 = 32'd0;
    case (f)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'd0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage valid/ready pipeline producing RV immediates and format codes
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (ILEN != 32) begin : g_bad_ilen
    $error("imm_gen_pipe: ILEN must be 32");
  end

  logic            s1_valid;
  logic [ILEN-1:0] s1_inst;
  logic            s2_valid;
  logic [XLEN-1:0] s2_imm;
  logic [2:0]      s2_fmt;
  logic            s2_illegal;
  logic            s1_advance;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = rst_n && (!s1_valid || s1_advance);

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (s1_inst),
    .fmt     (dec_fmt),
    .illegal (dec_illegal),
    .imm     (dec_imm)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_inst    <= '0;
      s2_valid   <= 1'b0;
      s2_imm     <= '0;
      s2_fmt     <= FMT_NONE;
      s2_illegal <= 1'b0;
    end else begin
      // Payload registers only load on a real transfer so stalled stages hold still.
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_imm     <= dec_imm;
          s2_fmt     <= dec_fmt;
          s2_illegal <= dec_illegal;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_inst <= in_inst;
        end
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_imm     = s2_imm;
  assign out_fmt     = s2_fmt;
  assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe at XLEN=64 with a shadow XLEN=32 instance
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        out_illegal32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .ILEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   flushed = 0;
  int   got = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pop on every output transfer; also guard out_* stability across stall cycles.
  logic        held = 1'b0;
  logic [63:0] h_imm;
  logic [2:0]  h_fmt;
  logic        h_ill;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output actual=%h required=none", out_imm);
      end else begin
        e = sb.pop_front();
        got++;
        chk("imm64", out_imm, e.imm);
        chk("fmt", {61'd0, out_fmt}, {61'd0, e.fmt});
        chk("illegal", {63'd0, out_illegal}, {63'd0, e.ill});
        chk("valid32", {63'd0, out_valid32}, 64'd1);
        chk("imm32", {32'd0, out_imm32}, {32'd0, e.imm[31:0]});
        chk("fmt32", {61'd0, out_fmt32}, {61'd0, e.fmt});
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
      end
    end
    if (rst_n && held) begin
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_imm", out_imm, h_imm);
      chk("stall_fmt", {61'd0, out_fmt}, {61'd0, h_fmt});
      chk("stall_ill", {63'd0, out_illegal}, {63'd0, h_ill});
    end
    held  = rst_n && out_valid && !out_ready;
    h_imm = out_imm;
    h_fmt = out_fmt;
    h_ill = out_illegal;
  end

  task automatic send(input logic [31:0] inst, input logic [63:0] imm, input logic [2:0] fmt,
                      input logic ill, input bit lat);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{imm, fmt, ill, cyc, lat});
        pushed++;
        done = 1;
      end else if (++n > 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout actual=in_ready_low required=accept inst=%h", inst);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'd0;
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_fmt", {61'd0, out_fmt}, 64'd7);
    chk("rst_out_ill", {63'd0, out_illegal}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Single I-type, then idle so the 2-cycle latency is seen in isolation.
    send(32'h65EA6E03, 64'h000000000000065E, 3'd1, 1'b0, 1'b1);
    idle(4);

    // Back-to-back stream covering every format and the illegal cases.
    send(32'hE5EA6E23, 64'hFFFFFFFFFFFFFE5C, 3'd2, 1'b0, 1'b1);
    send(32'hE5EA6E63, 64'hFFFFFFFFFFFFF65C, 3'd3, 1'b0, 1'b1);
    send(32'hE5EA6E33, 64'h0000000000000000, 3'd0, 1'b0, 1'b1);
    send(32'h12345037, 64'h0000000012345000, 3'd4, 1'b0, 1'b1);
    send(32'h80000017, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b1);
    send(32'hFFDFF0EF, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 1'b1);
    send(32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1, 1'b1);
    send(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b1);
    send(32'h00C50067, 64'h000000000000000C, 3'd1, 1'b0, 1'b1);
    send(32'h0010009B, 64'h0000000000000001, 3'd1, 1'b0, 1'b1);
    send(32'h00000073, 64'h0000000000000000, 3'd1, 1'b0, 1'b1);
    send(32'h0000003B, 64'h0000000000000000, 3'd0, 1'b0, 1'b1);
    send(32'h00000012, 64'h0000000000000000, 3'd7, 1'b1, 1'b1);
    idle(4);
    chk("drain1_empty", 64'(sb.size()), 64'd0);

    // Backpressure: consumer stalls 4 cycles while three inputs are offered.
    out_ready = 1'b0;
    send(32'hE5EA6E23, 64'hFFFFFFFFFFFFFE5C, 3'd2, 1'b0, 1'b0);
    send(32'h12345037, 64'h0000000012345000, 3'd4, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_inst  = 32'hFFDFF0EF;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'hFFDFF0EF, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 1'b0);
    idle(5);
    chk("drain2_empty", 64'(sb.size()), 64'd0);

    // Reset with both stages full: nothing in flight may ever emerge.
    out_ready = 1'b0;
    send(32'h80000017, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0);
    send(32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_inst  = 32'h65EA6E03;
    flushed += sb.size();
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_imm", out_imm, 64'd0);
    chk("post_rst_fmt", {61'd0, out_fmt}, 64'd7);
    chk("post_rst_ill", {63'd0, out_illegal}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(6);

    // Pipeline still works after reset.
    send(32'h65EA6E03, 64'h000000000000065E, 3'd1, 1'b0, 1'b1);
    idle(4);
    chk("final_empty", 64'(sb.size()), 64'd0);
    chk("result_count", 64'(got), 64'(pushed - flushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
